dut_io_sequencer: RTL and testbench
===================================

Name: dut_io_sequencer

Overview:
- Initiator-side companion to the DUT I/O unpack block.
- Accepts a valid/ready stream of 32-bit words from the AXI side and issues addressed word writes into the unpack block's input lanes.
- Pulses the DUT start, waits for the DUT's done, then issues addressed word reads from the output lanes and returns them as a valid/ready stream with a last flag.

Parameters:
- DUT_INPUT_WIDTH, 256: DUT input vector width in bits; IN_WORDS = ceil(DUT_INPUT_WIDTH/32).
- DUT_OUTPUT_WIDTH, 256: DUT output vector width in bits; OUT_WORDS = ceil(DUT_OUTPUT_WIDTH/32).
- TIMEOUT_CYCLES, 1024: WAIT-state cycle limit; used only with the optional feature.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- s_word_data  in  32  inbound input-vector word.
- s_word_valid  in  1  inbound word valid.
- s_word_ready  out  1  inbound word ready.
- m_word_data  out  32  outbound output-vector word.
- m_word_valid  out  1  outbound valid.
- m_word_ready  in  1  outbound ready.
- m_word_last  out  1  marks word OUT_WORDS-1.
- dut_input_vec_addr  out  32  input lane index.
- dut_input_vec_from_axi  out  32  input lane write data.
- input_vec_en  out  1  input lane write strobe.
- input_vec_mode  out  1  held 0 (addressed access).
- dut_output_vec_addr  out  32  output lane index.
- dut_output_vec_to_axi  in  32  output lane read data, valid the cycle after output_vec_en.
- output_vec_en  out  1  output lane read strobe.
- output_vec_mode  out  1  held 0.
- dut_start  out  1  one-cycle start pulse.
- dut_done  in  1  DUT completion, level or pulse.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; both word indices reset to 0.
  - All outputs go to 0.
  - Lane buffer contents are not touched.
  - Reset mid-transaction abandons it with no partial output.
- Address outputs: word index zero-extended to 32 bits. Index counters are max(clog2(N),1) bits wide and never wrap past N-1.
- States: IDLE, LOAD, START, WAIT, RD_REQ, RD_CAP, SEND.
- IDLE / LOAD:
  - s_word_ready=1.
  - Each handshake registers input_vec_en=1, addr=in_idx and data=s_word_data for exactly the next cycle.
  - in_idx increments per handshake.
  - On the handshake of word IN_WORDS-1 (including IN_WORDS=1 taken in IDLE), go to START. Otherwise IDLE goes to LOAD after the first word.
  - No handshake keeps the state.
- START:
  - s_word_ready=0.
  - The last write strobe is visible this cycle.
  - Next cycle go to WAIT, with dut_start=1 for that single cycle. The start pulse is therefore strictly after the final write.
- WAIT:
  - dut_done is ignored while dut_start=1.
  - Afterwards, dut_done=1 causes a move to RD_REQ with out_idx=0.
- RD_REQ: output_vec_en=1, dut_output_vec_addr=out_idx for one cycle; go to RD_CAP.
- RD_CAP: capture dut_output_vec_to_axi into m_word_data; go to SEND.
- SEND:
  - m_word_valid=1 and m_word_last=(out_idx==OUT_WORDS-1).
  - Data is held stable until m_word_ready.
  - On handshake, the last word goes to IDLE (in_idx=0); otherwise out_idx++ and go to RD_REQ.
  - Throughput is 1 word per 3 cycles when m_word_ready=1.
- s_word_valid outside IDLE/LOAD is back-pressured (ready=0), never dropped.
- dut_done asserted outside WAIT has no effect.

Optional Feature:
- Macro: DUT_IOSEQ_TIMEOUT_EN.
- With the macro:
  - Adds output port timeout_err (1 bit, reset 0).
  - A counter runs in WAIT from the cycle after dut_start.
  - If dut_done is still absent when the count reaches TIMEOUT_CYCLES, set timeout_err (sticky) and go to IDLE with no readout.
  - timeout_err clears on the next word-0 handshake in IDLE.
- Without the macro: no port, no counter, and WAIT waits indefinitely.

Decomposition:
- Shared header dut_io_defs.vh, holding:
  - the words-from-width ceiling macro (shared with the unpack block),
  - the 3-bit state encodings,
  - the mode encoding (0 = addressed access).
- One natural sub-module, dut_io_word_counter:
  - parameterised terminal count;
  - inc, clr, at_last outputs;
  - async active-low reset.
  - Instantiated twice (in_idx, out_idx).

Test Plan:
- Widths 256/256: stream words 0x11110000+i for i=0..7 -> eight input_vec_en cycles with addr 0..7. dut_start pulses exactly 1 cycle after the addr-7 strobe.
- Output readback: after dut_done, a model returns 0xA0000000+addr -> m_word_data sequence 0xA0000000..0xA0000007. m_word_last is set only on the 8th word; busy drops the cycle after the last handshake.
- Back-pressure: hold m_word_ready=0 for 5 cycles on word 3 -> data stays stable, output_vec_en stays low and out_idx stays at 3.
- Widths 40/33: IN_WORDS=2, OUT_WORDS=2 -> exactly 2 writes (addr 0,1) and 2 reads. dut_done held high during the dut_start cycle is ignored that cycle.
- Reset mid-transaction: reset=0 in the 2nd cycle of SEND -> all outputs 0 immediately. A new 8-word load after release works from addr 0.
- With DUT_IOSEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16: never assert dut_done -> timeout_err=1 after 16 WAIT cycles, state IDLE, no output_vec_en. The next word-0 handshake clears timeout_err.

Source files
------------

// File: rtl/dut_io_sequencer_pkg.sv
// Shared definitions for the DUT I/O sequencer: FSM state encodings,
// lane access mode, and the word-count / index-width helpers.
package dut_io_sequencer_pkg;

    // FSM states, 3-bit encoding shared with the unpack-side tooling
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RD_REQ = 3'd4,
        ST_RD_CAP = 3'd5,
        ST_SEND   = 3'd6
    } state_e;

    // Lane access mode: 0 selects addressed word access
    localparam logic MODE_ADDRESSED = 1'b0;

    // Number of 32-bit words needed to carry a vector of the given width
    function automatic int words_from_width(input int width);
        return (width + 31) / 32;
    endfunction

    // Index counter width: never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dut_io_word_counter.sv
// Saturating word index counter: counts 0..N-1, holds at N-1,
// synchronous clear, asynchronous active-low reset.
module dut_io_word_counter
    import dut_io_sequencer_pkg::*;
#(
    parameter int N = 8,
    parameter int W = idx_width(N)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_count,
    output logic         o_at_last
);

    localparam logic [W-1:0] LAST_IDX = W'(N - 1);

    logic [W-1:0] r_count;

    // Index register: clear wins over increment, increment stops at the last word
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != LAST_IDX)) begin
            r_count <= r_count + W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count   = r_count;
    assign o_at_last = (r_count == LAST_IDX);

endmodule

// File: rtl/dut_io_sequencer.sv
// Initiator-side sequencer for the DUT I/O unpack block: loads input lanes
// from a word stream, pulses dut_start, waits for dut_done, then reads the
// output lanes back as a word stream with a last flag.
// Optional feature macro: DUT_IOSEQ_TIMEOUT_EN adds a WAIT watchdog and the
// sticky timeout_err output (TIMEOUT_CYCLES parameter exists only then).
module dut_io_sequencer
    import dut_io_sequencer_pkg::*;
#(
    parameter int DUT_INPUT_WIDTH  = 256,
    parameter int DUT_OUTPUT_WIDTH = 256
`ifdef DUT_IOSEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES   = 1024
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] s_word_data,
    input  logic        s_word_valid,
    output logic        s_word_ready,
    output logic [31:0] m_word_data,
    output logic        m_word_valid,
    input  logic        m_word_ready,
    output logic        m_word_last,
    output logic [31:0] dut_input_vec_addr,
    output logic [31:0] dut_input_vec_from_axi,
    output logic        input_vec_en,
    output logic        input_vec_mode,
    output logic [31:0] dut_output_vec_addr,
    input  logic [31:0] dut_output_vec_to_axi,
    output logic        output_vec_en,
    output logic        output_vec_mode,
    output logic        dut_start,
    input  logic        dut_done,
    output logic        busy
`ifdef DUT_IOSEQ_TIMEOUT_EN
    ,
    output logic        timeout_err
`endif
);

    localparam int IN_WORDS  = words_from_width(DUT_INPUT_WIDTH);
    localparam int OUT_WORDS = words_from_width(DUT_OUTPUT_WIDTH);
    localparam int IN_W      = idx_width(IN_WORDS);
    localparam int OUT_W     = idx_width(OUT_WORDS);

    state_e      r_state;
    logic        r_s_ready;
    logic        r_in_en;
    logic [31:0] r_in_addr;
    logic [31:0] r_in_data;
    logic        r_out_en;
    logic [31:0] r_out_addr;
    logic        r_start;
    logic [31:0] r_m_data;
    logic        r_m_valid;
    logic        r_m_last;
    logic        r_busy;

    logic [IN_W-1:0]  w_in_idx;
    logic [OUT_W-1:0] w_out_idx;
    logic             w_in_last;
    logic             w_out_last;
    logic             w_in_hs;
    logic             w_m_hs;
    logic             w_done_seen;
    logic             w_to_expire;
    logic             w_in_clr;
    logic             w_out_inc;

`ifdef DUT_IOSEQ_TIMEOUT_EN
    localparam int               TO_W    = idx_width(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout_err;
    assign w_to_expire = (r_state == ST_WAIT) && !r_start && !dut_done
                         && (r_to_cnt == TO_LAST);
    assign timeout_err = r_timeout_err;
`else
    assign w_to_expire = 1'b0;
`endif

    // ready is only ever high in IDLE/LOAD, valid only in SEND
    assign w_in_hs     = s_word_valid & r_s_ready;
    assign w_m_hs      = r_m_valid & m_word_ready;
    assign w_done_seen = (r_state == ST_WAIT) && !r_start && dut_done;
    assign w_in_clr    = (w_m_hs && w_out_last) || w_to_expire;
    assign w_out_inc   = w_m_hs && !w_out_last;

    dut_io_word_counter #(.N(IN_WORDS), .W(IN_W)) u_in_idx (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .i_inc     (w_in_hs),
        .i_clr     (w_in_clr),
        .o_count   (w_in_idx),
        .o_at_last (w_in_last)
    );

    dut_io_word_counter #(.N(OUT_WORDS), .W(OUT_W)) u_out_idx (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .i_inc     (w_out_inc),
        .i_clr     (w_done_seen),
        .o_count   (w_out_idx),
        .o_at_last (w_out_last)
    );

    // Sequencer FSM with all stream/lane outputs registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_s_ready  <= 1'b0;
            r_in_en    <= 1'b0;
            r_in_addr  <= 32'd0;
            r_in_data  <= 32'd0;
            r_out_en   <= 1'b0;
            r_out_addr <= 32'd0;
            r_start    <= 1'b0;
            r_m_data   <= 32'd0;
            r_m_valid  <= 1'b0;
            r_m_last   <= 1'b0;
            r_busy     <= 1'b0;
`ifdef DUT_IOSEQ_TIMEOUT_EN
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            // strobes default low so each lasts exactly one cycle
            r_in_en  <= 1'b0;
            r_out_en <= 1'b0;
            r_start  <= 1'b0;
            case (r_state)
                ST_IDLE, ST_LOAD: begin
                    if (w_in_hs) begin
                        r_in_en   <= 1'b1;
                        r_in_addr <= 32'(w_in_idx);
                        r_in_data <= s_word_data;
                        r_busy    <= 1'b1;
`ifdef DUT_IOSEQ_TIMEOUT_EN
                        if (r_state == ST_IDLE) begin
                            r_timeout_err <= 1'b0;
                        end else begin
                            r_timeout_err <= r_timeout_err;
                        end
`endif
                        if (w_in_last) begin
                            r_state   <= ST_START;
                            r_s_ready <= 1'b0;
                        end else begin
                            r_state   <= ST_LOAD;
                            r_s_ready <= 1'b1;
                        end
                    end else begin
                        r_s_ready <= 1'b1;
                        r_busy    <= (r_state != ST_IDLE);
                    end
                end
                ST_START: begin
                    // final write strobe is visible now; start follows it
                    r_state <= ST_WAIT;
                    r_start <= 1'b1;
`ifdef DUT_IOSEQ_TIMEOUT_EN
                    r_to_cnt <= '0;
`endif
                end
                ST_WAIT: begin
                    if (r_start) begin
                        r_state <= ST_WAIT;
                    end else if (dut_done) begin
                        r_state    <= ST_RD_REQ;
                        r_out_en   <= 1'b1;
                        r_out_addr <= 32'd0;
                    end else begin
`ifdef DUT_IOSEQ_TIMEOUT_EN
                        if (w_to_expire) begin
                            r_state       <= ST_IDLE;
                            r_timeout_err <= 1'b1;
                            r_s_ready     <= 1'b1;
                            r_busy        <= 1'b0;
                        end else begin
                            r_to_cnt <= r_to_cnt + TO_W'(1);
                        end
`else
                        r_state <= ST_WAIT;
`endif
                    end
                end
                ST_RD_REQ: begin
                    r_state <= ST_RD_CAP;
                end
                ST_RD_CAP: begin
                    // lane data is valid the cycle after the read strobe
                    r_m_data  <= dut_output_vec_to_axi;
                    r_m_valid <= 1'b1;
                    r_m_last  <= w_out_last;
                    r_state   <= ST_SEND;
                end
                ST_SEND: begin
                    if (m_word_ready) begin
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                        if (w_out_last) begin
                            r_state   <= ST_IDLE;
                            r_s_ready <= 1'b1;
                            r_busy    <= 1'b0;
                        end else begin
                            r_state    <= ST_RD_REQ;
                            r_out_en   <= 1'b1;
                            r_out_addr <= 32'(w_out_idx) + 32'd1;
                        end
                    end else begin
                        r_state <= ST_SEND;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_s_ready <= 1'b0;
                    r_m_valid <= 1'b0;
                    r_m_last  <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign s_word_ready           = r_s_ready;
    assign m_word_data            = r_m_data;
    assign m_word_valid           = r_m_valid;
    assign m_word_last            = r_m_last;
    assign dut_input_vec_addr     = r_in_addr;
    assign dut_input_vec_from_axi = r_in_data;
    assign input_vec_en           = r_in_en;
    assign input_vec_mode         = MODE_ADDRESSED;
    assign dut_output_vec_addr    = r_out_addr;
    assign output_vec_en          = r_out_en;
    assign output_vec_mode        = MODE_ADDRESSED;
    assign dut_start              = r_start;
    assign busy                   = r_busy;

endmodule

// File: tb/tb_dut_io_sequencer.sv
// Bench for dut_io_sequencer: instance A (256/256) and instance B (40/33)
// share one stimulus driver selected by sel; a lane model answers reads.
// Build with DUT_IOSEQ_TIMEOUT_EN to also exercise the WAIT watchdog.
module tb_dut_io_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        sel;
    logic [31:0] tb_s_data;
    logic        tb_s_valid, tb_m_ready, tb_done;
    logic [31:0] rd_data;
    logic [31:0] mem [8];

    logic        a_s_ready, a_m_valid, a_m_last, a_in_en, a_in_mode, a_out_en, a_out_mode, a_start, a_busy;
    logic [31:0] a_m_data, a_in_addr, a_in_data, a_out_addr;
    logic        b_s_ready, b_m_valid, b_m_last, b_in_en, b_in_mode, b_out_en, b_out_mode, b_start, b_busy;
    logic [31:0] b_m_data, b_in_addr, b_in_data, b_out_addr;
`ifdef DUT_IOSEQ_TIMEOUT_EN
    logic        a_terr, b_terr;
`endif

    wire         a_s_valid = ~sel & tb_s_valid;
    wire         b_s_valid =  sel & tb_s_valid;
    wire [31:0]  a_s_data  = sel ? 32'd0 : tb_s_data;
    wire [31:0]  b_s_data  = sel ? tb_s_data : 32'd0;
    wire         a_m_ready = ~sel & tb_m_ready;
    wire         b_m_ready =  sel & tb_m_ready;
    wire         a_done    = ~sel & tb_done;
    wire         b_done    =  sel & tb_done;

    wire         o_s_ready  = sel ? b_s_ready  : a_s_ready;
    wire         o_m_valid  = sel ? b_m_valid  : a_m_valid;
    wire         o_m_last   = sel ? b_m_last   : a_m_last;
    wire [31:0]  o_m_data   = sel ? b_m_data   : a_m_data;
    wire         o_in_en    = sel ? b_in_en    : a_in_en;
    wire [31:0]  o_in_addr  = sel ? b_in_addr  : a_in_addr;
    wire [31:0]  o_in_data  = sel ? b_in_data  : a_in_data;
    wire         o_in_mode  = sel ? b_in_mode  : a_in_mode;
    wire         o_out_en   = sel ? b_out_en   : a_out_en;
    wire [31:0]  o_out_addr = sel ? b_out_addr : a_out_addr;
    wire         o_out_mode = sel ? b_out_mode : a_out_mode;
    wire         o_start    = sel ? b_start    : a_start;
    wire         o_busy     = sel ? b_busy     : a_busy;

    dut_io_sequencer #(
        .DUT_INPUT_WIDTH(256), .DUT_OUTPUT_WIDTH(256)
`ifdef DUT_IOSEQ_TIMEOUT_EN
        , .TIMEOUT_CYCLES(16)
`endif
    ) u_dut_a (
        .clk(clk), .reset(reset),
        .s_word_data(a_s_data), .s_word_valid(a_s_valid), .s_word_ready(a_s_ready),
        .m_word_data(a_m_data), .m_word_valid(a_m_valid), .m_word_ready(a_m_ready), .m_word_last(a_m_last),
        .dut_input_vec_addr(a_in_addr), .dut_input_vec_from_axi(a_in_data),
        .input_vec_en(a_in_en), .input_vec_mode(a_in_mode),
        .dut_output_vec_addr(a_out_addr), .dut_output_vec_to_axi(rd_data),
        .output_vec_en(a_out_en), .output_vec_mode(a_out_mode),
        .dut_start(a_start), .dut_done(a_done), .busy(a_busy)
`ifdef DUT_IOSEQ_TIMEOUT_EN
        , .timeout_err(a_terr)
`endif
    );

    dut_io_sequencer #(
        .DUT_INPUT_WIDTH(40), .DUT_OUTPUT_WIDTH(33)
    ) u_dut_b (
        .clk(clk), .reset(reset),
        .s_word_data(b_s_data), .s_word_valid(b_s_valid), .s_word_ready(b_s_ready),
        .m_word_data(b_m_data), .m_word_valid(b_m_valid), .m_word_ready(b_m_ready), .m_word_last(b_m_last),
        .dut_input_vec_addr(b_in_addr), .dut_input_vec_from_axi(b_in_data),
        .input_vec_en(b_in_en), .input_vec_mode(b_in_mode),
        .dut_output_vec_addr(b_out_addr), .dut_output_vec_to_axi(rd_data),
        .output_vec_en(b_out_en), .output_vec_mode(b_out_mode),
        .dut_start(b_start), .dut_done(b_done), .busy(b_busy)
`ifdef DUT_IOSEQ_TIMEOUT_EN
        , .timeout_err(b_terr)
`endif
    );

    // Output lane model: read data appears the cycle after the strobe
    always @(posedge clk) begin
        if (o_out_en) rd_data <= mem[o_out_addr[2:0]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$];
    int          wr_cyc_q[$], rd_cyc_q[$], start_cyc_q[$];

    // Event log of lane strobes and start pulses, sampled mid-cycle
    always @(negedge clk) begin
        if (o_in_en) begin
            wr_addr_q.push_back(o_in_addr);
            wr_data_q.push_back(o_in_data);
            wr_cyc_q.push_back(cyc);
        end
        if (o_out_en) begin
            rd_addr_q.push_back(o_out_addr);
            rd_cyc_q.push_back(cyc);
        end
        if (o_start) start_cyc_q.push_back(cyc);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic probe(input int what);
        case (what)
            0:       return o_s_ready;
            1:       return o_m_valid;
            2:       return o_start;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int what, input string tag);
        logic hit;
        hit = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (probe(what)) begin
                hit = 1'b1;
                break;
            end
        end
        check({tag, "_wait"}, {31'd0, hit}, 32'd1);
    endtask

    task automatic push_word(input logic [31:0] d);
        wait_for(0, "s_ready");
        tb_s_valid = 1'b1;
        tb_s_data  = d;
        @(posedge clk);
        #1 tb_s_valid = 1'b0;
    endtask

    task automatic clear_logs();
        @(posedge clk);
        #1;
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        rd_addr_q.delete(); rd_cyc_q.delete(); start_cyc_q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_s_ready"}, {31'd0, o_s_ready}, 32'd0);
        check({tag, "_m_valid"}, {31'd0, o_m_valid}, 32'd0);
        check({tag, "_m_last"},  {31'd0, o_m_last},  32'd0);
        check({tag, "_m_data"},  o_m_data,   32'd0);
        check({tag, "_in_en"},   {31'd0, o_in_en},   32'd0);
        check({tag, "_in_addr"}, o_in_addr,  32'd0);
        check({tag, "_in_data"}, o_in_data,  32'd0);
        check({tag, "_out_en"},  {31'd0, o_out_en},  32'd0);
        check({tag, "_out_addr"}, o_out_addr, 32'd0);
        check({tag, "_modes"},   {30'd0, o_in_mode, o_out_mode}, 32'd0);
        check({tag, "_start"},   {31'd0, o_start},   32'd0);
        check({tag, "_busy"},    {31'd0, o_busy},    32'd0);
    endtask

    // One full load/start/readback transaction against the reference model
    task automatic run_txn(input int bp_word, input int bp_len, input bit early, input bit rnd);
        int          n;
        logic [31:0] words [8];
        n = sel ? 2 : 8;
        clear_logs();
        for (int k = 0; k < 8; k++) mem[k] = rnd ? $urandom() : (32'hA000_0000 + 32'(k));
        for (int i = 0; i < n; i++) begin
            words[i] = rnd ? $urandom() : (32'h1111_0000 + 32'(i));
            push_word(words[i]);
        end
        if (early) tb_done = 1'b1;
        check("start_state_ready_low", {31'd0, o_s_ready}, 32'd0);
        wait_for(2, "dut_start");
        if (!early) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            tb_done = 1'b1;
        end
        for (int k = 0; k < n; k++) begin
            wait_for(1, "m_valid");
            tb_done = 1'b0;
            check("m_data", o_m_data, mem[k]);
            check("m_last", {31'd0, o_m_last}, (k == n - 1) ? 32'd1 : 32'd0);
            if (k == bp_word) begin
                for (int j = 0; j < bp_len; j++) begin
                    @(negedge clk);
                    check("bp_data", o_m_data, mem[k]);
                    check("bp_valid", {31'd0, o_m_valid}, 32'd1);
                    check("bp_no_read", {31'd0, o_out_en}, 32'd0);
                    check("bp_out_addr", o_out_addr, 32'(k));
                end
            end
            tb_m_ready = 1'b1;
            @(posedge clk);
            #1 tb_m_ready = 1'b0;
        end
        @(negedge clk);
        check("end_busy", {31'd0, o_busy}, 32'd0);
        check("end_m_valid", {31'd0, o_m_valid}, 32'd0);
        check("end_s_ready", {31'd0, o_s_ready}, 32'd1);
        check("wr_count", 32'(wr_addr_q.size()), 32'(n));
        if (wr_addr_q.size() == n) begin
            for (int i = 0; i < n; i++) begin
                check("wr_addr", wr_addr_q[i], 32'(i));
                check("wr_data", wr_data_q[i], words[i]);
            end
        end
        check("start_count", 32'(start_cyc_q.size()), 32'd1);
        if (start_cyc_q.size() == 1 && wr_cyc_q.size() == n)
            check("start_after_last_wr", 32'(start_cyc_q[0]), 32'(wr_cyc_q[n-1] + 1));
        check("rd_count", 32'(rd_addr_q.size()), 32'(n));
        if (rd_addr_q.size() == n) begin
            for (int k = 0; k < n; k++) begin
                check("rd_addr", rd_addr_q[k], 32'(k));
                if (k > 0 && (k - 1) != bp_word)
                    check("rd_spacing", 32'(rd_cyc_q[k] - rd_cyc_q[k-1]), 32'd3);
            end
            if (early && start_cyc_q.size() == 1)
                check("done_ignored_on_start", 32'(rd_cyc_q[0]), 32'(start_cyc_q[0] + 2));
        end
    endtask

    initial begin
        reset      = 1'b0;
        sel        = 1'b0;
        tb_s_data  = 32'd0;
        tb_s_valid = 1'b0;
        tb_m_ready = 1'b0;
        tb_done    = 1'b0;
        for (int k = 0; k < 8; k++) mem[k] = 32'd0;

        // reset values
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b1;
        @(negedge clk);
        check("idle_ready", {31'd0, o_s_ready}, 32'd1);
        check("idle_busy", {31'd0, o_busy}, 32'd0);

        // directed 256/256 transfer, then back-pressure on word 3
        run_txn(-1, 0, 1'b0, 1'b0);
        run_txn(3, 5, 1'b0, 1'b0);

        // 40/33 widths with dut_done high across the start cycle
        sel = 1'b1;
        run_txn(-1, 0, 1'b1, 1'b0);

        // reset in the second SEND cycle, then a clean reload
        sel = 1'b0;
        clear_logs();
        for (int i = 0; i < 8; i++) push_word(32'h2222_0000 + 32'(i));
        wait_for(2, "rst_start");
        tb_done = 1'b1;
        wait_for(1, "rst_m_valid");
        tb_done = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        #1 check_outputs_zero("mid_reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run_txn(-1, 0, 1'b0, 1'b0);

        // randomized transactions on both instances
        for (int r = 0; r < 6; r++) begin
            sel = r[0];
            run_txn($urandom_range(0, sel ? 1 : 7), $urandom_range(0, 4),
                    1'($urandom_range(0, 1)), 1'b1);
        end

`ifdef DUT_IOSEQ_TIMEOUT_EN
        // watchdog: dut_done never arrives
        sel = 1'b0;
        clear_logs();
        for (int i = 0; i < 8; i++) push_word($urandom());
        wait_for(2, "to_start");
        repeat (16) @(negedge clk);
        check("to_err_before_limit", {31'd0, a_terr}, 32'd0);
        check("to_busy_before_limit", {31'd0, a_busy}, 32'd1);
        @(negedge clk);
        check("to_err_set", {31'd0, a_terr}, 32'd1);
        check("to_idle", {31'd0, a_busy}, 32'd0);
        check("to_no_reads", 32'(rd_addr_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        check("to_err_sticky", {31'd0, a_terr}, 32'd1);
        push_word(32'h0BAD_F00D);
        check("to_err_cleared", {31'd0, a_terr}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
